bcd_stopwatch_ctrl: RTL and testbench

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

---
 rtl/bcd_stopwatch_ctrl.sv | 98 +++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM driving a cascaded BCD counter
// with lap capture and a sticky wrap-around flag. All outputs are registered.
module bcd_stopwatch_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   lap_val,
  output logic                  lap_valid,
  output logic                  running,
  output logic                  ovf,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t               st, st_nxt;
  logic [4*DIGITS-1:0]  cnt_inc;
  logic                 all_nine;

  assign state = st;

  // Ripple BCD increment; carry out of the top digit means all digits were 9.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    cnt_inc = count;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nine = carry;
  end

  // Stop outranks start even where stop itself has no effect (IDLE/PAUSE).
  always_comb begin
    st_nxt = st;
    if (clear) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:    if (start && !stop) st_nxt = RUN;
        RUN:     if (stop)           st_nxt = PAUSE;
        PAUSE:   if (start && !stop) st_nxt = RUN;
        default:                     st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      running   <= 1'b0;
      count     <= '0;
      lap_val   <= '0;
      lap_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      st        <= st_nxt;
      running   <= (st_nxt == RUN);
      lap_valid <= 1'b0;
      if (clear) begin
        count   <= '0;
        lap_val <= '0;
        ovf     <= 1'b0;
      end else if (st == BAD) begin
        count <= '0;
      end else begin
        if (st == RUN && tick) begin
          count <= cnt_inc;
          if (all_nine) ovf <= 1'b1;
        end
        if (lap && (st == RUN || st == PAUSE)) begin
          lap_val   <= count;
          lap_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: 4-digit and 2-digit instances share stimulus and
// are compared each cycle against an integer-valued stopwatch model.
module tb_bcd_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n, tick, start, stop, clear, lap;

  logic [15:0] count4, lap_val4;
  logic        lap_valid4, running4, ovf4;
  logic [1:0]  state4;
  logic [7:0]  count2, lap_val2;
  logic        lap_valid2, running2, ovf2;
  logic [1:0]  state2;

  bcd_stopwatch_ctrl #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .count(count4), .lap_val(lap_val4),
    .lap_valid(lap_valid4), .running(running4), .ovf(ovf4), .state(state4)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .count(count2), .lap_val(lap_val2),
    .lap_valid(lap_valid2), .running(running2), .ovf(ovf2), .state(state2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: state 0=idle 1=run 2=pause; counts kept as plain decimal integers.
  int m_state, m_cnt4, m_cnt2, m_lap4, m_lap2;
  bit m_ovf4, m_ovf2, m_lv;

  logic [57:0] obs;
  assign obs = {state4, running4, ovf4, lap_valid4, lap_val4, count4,
                state2, running2, ovf2, lap_valid2, lap_val2, count2};

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [57:0] exp_vec();
    logic [31:0] a, b, c, d;
    logic [1:0]  s;
    a = to_bcd(m_lap4);
    b = to_bcd(m_cnt4);
    c = to_bcd(m_lap2);
    d = to_bcd(m_cnt2);
    s = 2'(m_state);
    return {s, (m_state == 1), m_ovf4, m_lv, a[15:0], b[15:0],
            s, (m_state == 1), m_ovf2, m_lv, c[7:0], d[7:0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt4 = 0; m_cnt2 = 0; m_lap4 = 0; m_lap2 = 0;
    m_ovf4 = 0; m_ovf2 = 0; m_lv = 0;
  endtask

  // One clock cycle of stimulus; called at a negedge, returns at the next negedge.
  task automatic step(input bit s, input bit p, input bit c, input bit l, input bit t);
    start = s; stop = p; clear = c; lap = l; tick = t;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (l && m_state != 0) begin
        m_lap4 = m_cnt4; m_lap2 = m_cnt2; m_lv = 1;
      end else begin
        m_lv = 0;
      end
      if (m_state == 1 && t) begin
        m_cnt4 = (m_cnt4 + 1) % 10000;
        if (m_cnt4 == 0) m_ovf4 = 1;
        m_cnt2 = (m_cnt2 + 1) % 100;
        if (m_cnt2 == 0) m_ovf2 = 1;
      end
      if (p) begin
        if (m_state == 1) m_state = 2;
      end else if (s && m_state != 1) begin
        m_state = 1;
      end
    end
    @(negedge clk);
    start = 0; stop = 0; clear = 0; lap = 0; tick = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; stop = 0; clear = 0; lap = 0; tick = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 58'd0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, 58'd0);
    end
    rst_n = 1;
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_count_carry();
    step(1, 0, 0, 0, 1);  // tick with start from IDLE is not counted
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h0010 || running4 !== 1'b1) begin
      errors++; $display("FAIL count_10: got %h/%b expected 0010/1", count4, running4);
    end
    for (int i = 0; i < 89; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h0099 || count2 !== 8'h99 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL count_99: got %h/%h/%b expected 0099/99/0", count4, count2, ovf2);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h0100 || count2 !== 8'h00 || ovf2 !== 1'b1 || ovf4 !== 1'b0) begin
      errors++; $display("FAIL carry_100: got %h/%h/%b/%b expected 0100/00/1/0",
                         count4, count2, ovf2, ovf4);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (count2 !== 8'h05 || ovf2 !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %h/%b expected 05/1", count2, ovf2);
    end
    for (int i = 0; i < 1894; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL count_run: got %h expected %h", obs, exp_vec());
      end
    end
    checks++;
    if (count4 !== 16'h1999) begin
      errors++; $display("FAIL count_1999: got %h expected 1999", count4);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h2000) begin
      errors++; $display("FAIL carry_2000: got %h expected 2000", count4);
    end
  endtask

  task automatic test_stop_start();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 37; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);  // tick alongside stop still counts
    checks++;
    if (state4 !== 2'b10 || count4 !== 16'h0038 || running4 !== 1'b0) begin
      errors++; $display("FAIL stop_tick: got %b/%h/%b expected 10/0038/0", state4, count4, running4);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h0038) begin
      errors++; $display("FAIL pause_hold: got %h expected 0038", count4);
    end
    step(1, 0, 0, 0, 1);
    checks++;
    if (state4 !== 2'b01 || running4 !== 1'b1 || count4 !== 16'h0038) begin
      errors++; $display("FAIL resume: got %b/%b/%h expected 01/1/0038", state4, running4, count4);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h0039) begin
      errors++; $display("FAIL resume_tick: got %h expected 0039", count4);
    end
  endtask

  task automatic test_lap();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);  // lap in IDLE ignored
    checks++;
    if (lap_valid4 !== 1'b0 || lap_val4 !== 16'h0000) begin
      errors++; $display("FAIL lap_idle: got %b/%h expected 0/0000", lap_valid4, lap_val4);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 42; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    checks++;
    if (lap_val4 !== 16'h0042 || lap_valid4 !== 1'b1 || count4 !== 16'h0043) begin
      errors++; $display("FAIL lap_capture: got %h/%b/%h expected 0042/1/0043",
                         lap_val4, lap_valid4, count4);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (lap_valid4 !== 1'b0 || lap_val4 !== 16'h0042) begin
      errors++; $display("FAIL lap_pulse: got %b/%h expected 0/0042", lap_valid4, lap_val4);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1);
      checks++;
      if (lap_valid4 !== 1'b1 || obs !== exp_vec()) begin
        errors++; $display("FAIL lap_held: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_clear_combo();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 123; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1);
    checks++;
    if (state4 !== 2'b00 || count4 !== 16'h0000 || lap_val4 !== 16'h0000 || lap_valid4 !== 1'b0) begin
      errors++; $display("FAIL clear_combo: got %b/%h/%h/%b expected 00/0000/0000/0",
                         state4, count4, lap_val4, lap_valid4);
    end
    step(1, 1, 0, 0, 1);
    checks++;
    if (state4 !== 2'b00 || running4 !== 1'b0 || count4 !== 16'h0000) begin
      errors++; $display("FAIL start_stop_idle: got %b/%b/%h expected 00/0/0000",
                         state4, running4, count4);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (count4 !== 16'h0500 || running4 !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got %h/%b expected 0500/1", count4, running4);
    end
    lap = 1; tick = 1;
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== 58'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", obs, 58'd0);
    end
    @(negedge clk);
    lap = 0; tick = 0;
    rst_n = 1;
    model_reset();
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL post_reset: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    bit s, p, c, l, t;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 5) == 0);
      l = ($urandom_range(0, 4) == 0);
      t = $urandom_range(0, 1) != 0;
      step(s, p, c, l, t);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_carry();
    test_stop_start();
    test_lap();
    test_clear_combo();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
